ext_master_arbiter: RTL and testbench
=====================================

Name: ext_master_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the system's single external-master bridge port among NREQ fabric requesters.
- The bridge port uses 30-bit word address, 4-bit byte enables, read/write strobes, 32-bit data and an acknowledge.
- Sits in the FPGA fabric between user logic (address-control masters, test pattern generators) and the external_master_external_interface_* pins of the system top.
- Serialises one transaction at a time and returns read data and completion pulses to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 30, address width.
- DW, 32, data width; byte-enable width is DW/8.
- TIMEOUT_CYCLES, 1024, cycles to wait for bus_acknowledge before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_address  in  NREQ*AW  packed per-requester address; slot i at [i*AW +: AW].
- req_byte_enable  in  NREQ*DW/8  packed byte enables.
- req_read  in  NREQ  read request, held until the matching req_ack.
- req_write  in  NREQ  write request, held until the matching req_ack.
- req_write_data  in  NREQ*DW  packed write data.
- req_ack  out  NREQ  one-cycle completion pulse for the granted requester.
- req_read_data  out  DW  read data, valid in the req_ack cycle.
- req_err  out  1  abort flag, valid with req_ack.
- bus_address  out  AW  to the bridge address.
- bus_byte_enable  out  DW/8  to the bridge byte_enable.
- bus_read  out  1  to the bridge read strobe.
- bus_write  out  1  to the bridge write strobe.
- bus_write_data  out  DW  to the bridge write_data.
- bus_acknowledge  in  1  from the bridge acknowledge.
- bus_read_data  in  DW  from the bridge read_data.
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n low at a clock edge):
  - All outputs go to 0.
  - FSM returns to IDLE; the round-robin pointer goes to 0.
  - Any in-flight transaction is abandoned with no req_ack.
  - Applies at any point, including mid-ISSUE.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - A requester is active when req_read[i] or req_write[i] is high.
  - Search starts at the pointer and wraps modulo NREQ; the first active requester wins.
  - On a win, register grant_id and the winner's address, byte enables and write data onto the bus outputs, then go to ISSUE.
  - Bus strobes assert on the cycle after the request is sampled: 1-cycle grant latency.
- Read/write conflict: if both req_read and req_write are high for the winner, the transaction is a read; the write is ignored.
- ISSUE:
  - Hold bus_read or bus_write and all bus fields stable until bus_acknowledge is sampled high.
  - On acknowledge: drop the strobes on the next edge, capture bus_read_data into req_read_data (reads only; writes leave it unchanged), pulse req_ack[grant_id], then go to DONE.
  - Minimum total latency from request to req_ack is 2 cycles when the bridge acknowledges in the first ISSUE cycle.
- DONE:
  - Single cycle. The requester must deassert its request during this cycle.
  - Advance pointer to (grant_id+1) mod NREQ, then return to IDLE.
  - A request still high in the following IDLE cycle is treated as a new transaction.
- bus_acknowledge seen outside ISSUE is ignored.
- req_ack is never asserted for a non-granted index and is never more than one cycle wide.
- Requests that change while not granted have no effect until they are sampled in IDLE.

Optional Feature:
- Macro: EXT_MASTER_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES without an acknowledge: drop the strobes, pulse req_ack[grant_id] with req_err=1 and req_read_data=32'hDEAD_BEEF, then go to DONE.
  - An acknowledge arriving in the same cycle as the timeout wins; req_err stays 0.
- When undefined:
  - ISSUE waits indefinitely.
  - req_err is tied to 0.
  - No counter is synthesised.

Test Plan:
- Single read: reset, req_read[0]=1, addr=0x0000_0400, bridge acks 3 cycles after strobe with 0x1234_5678 -> bus_read high for 3 cycles, req_ack[0] pulses once, req_read_data=0x1234_5678, busy low 1 cycle after DONE.
- Round-robin: all four req_write held continuously, zero-wait bridge -> grant order 0,1,2,3,0; each req_ack is 1 cycle wide, bus_write_data matches the granted slot.
- Read/write conflict: req_read[2]=req_write[2]=1 -> bus_read=1, bus_write=0 throughout.
- Reset mid-ISSUE: reset_n low for 1 cycle while bus_read is high -> next cycle all outputs 0, no req_ack, pointer 0, and requester 0 wins next.
- Timeout (EXT_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8): bridge never acks -> after 8 ISSUE cycles req_ack[1] pulses, req_err=1, req_read_data=0xDEAD_BEEF. Repeat with ack on cycle 8 -> req_err=0.
- Stray ack: bus_acknowledge pulsed in IDLE -> no req_ack, state unchanged.

Source files
------------

// File: rtl/ext_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one external-master bridge port among NREQ requesters.
// Defining EXT_MASTER_TIMEOUT_EN adds an acknowledge timeout that aborts with req_err and 32'hDEAD_BEEF.
module ext_master_arbiter #(
    parameter int NREQ           = 4,
    parameter int AW             = 30,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ*AW-1:0]      req_address,
    input  logic [NREQ*(DW/8)-1:0]  req_byte_enable,
    input  logic [NREQ-1:0]         req_read,
    input  logic [NREQ-1:0]         req_write,
    input  logic [NREQ*DW-1:0]      req_write_data,
    output logic [NREQ-1:0]         req_ack,
    output logic [DW-1:0]           req_read_data,
    output logic                    req_err,
    output logic [AW-1:0]           bus_address,
    output logic [DW/8-1:0]         bus_byte_enable,
    output logic                    bus_read,
    output logic                    bus_write,
    output logic [DW-1:0]           bus_write_data,
    input  logic                    bus_acknowledge,
    input  logic [DW-1:0]           bus_read_data,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int BW = DW / 8;
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Handshake: a requester holds req_read/req_write until its one-cycle req_ack;
    // the bus strobe and fields stay stable until bus_acknowledge is sampled in ISSUE.
    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BW-1:0]    be_q, be_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [NREQ-1:0]  ack_q, ack_d;
`ifdef EXT_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]      cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic [15:0]      unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand_idx;

    // Search from the pointer, wrapping modulo NREQ; first active requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && (req_read[cand_idx] || req_write[cand_idx])) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ack_d   = '0;
`ifdef EXT_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    addr_d  = req_address[int'(win_idx)*AW +: AW];
                    be_d    = req_byte_enable[int'(win_idx)*BW +: BW];
                    wdata_d = req_write_data[int'(win_idx)*DW +: DW];
                    // A read wins over a simultaneous write.
                    rd_d    = req_read[win_idx];
                    wr_d    = ~req_read[win_idx];
                    state_d = ST_ISSUE;
`ifdef EXT_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (bus_acknowledge) begin
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    if (rd_q) begin
                        rdata_d = bus_read_data;
                    end
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_DONE;
                end
`ifdef EXT_MASTER_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    rdata_d        = DW'(32'hDEAD_BEEF);
                    err_d          = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_DONE: begin
                ptr_d   = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= '0;
`ifdef EXT_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
`ifdef EXT_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign req_ack         = ack_q;
    assign req_read_data   = rdata_q;
`ifdef EXT_MASTER_TIMEOUT_EN
    assign req_err         = err_q;
`else
    assign req_err         = 1'b0;
`endif
    assign bus_address     = addr_q;
    assign bus_byte_enable = be_q;
    assign bus_read        = rd_q;
    assign bus_write       = wr_q;
    assign bus_write_data  = wdata_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q != ST_IDLE);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_ext_master_arbiter.sv
// Self-checking bench for ext_master_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_ext_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 30;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int IW   = 2;
    localparam int TO   = 8;

    // Clock / reset
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ*AW-1:0] req_address;
    logic [NREQ*BW-1:0] req_byte_enable;
    logic [NREQ-1:0]    req_read;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*DW-1:0] req_write_data;
    logic [NREQ-1:0]    req_ack;
    logic [DW-1:0]      req_read_data;
    logic               req_err;
    logic [AW-1:0]      bus_address;
    logic [BW-1:0]      bus_byte_enable;
    logic               bus_read;
    logic               bus_write;
    logic [DW-1:0]      bus_write_data;
    logic               bus_acknowledge;
    logic [DW-1:0]      bus_read_data;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic [1:0]         dbg_state;

    ext_master_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_address(req_address), .req_byte_enable(req_byte_enable),
        .req_read(req_read), .req_write(req_write), .req_write_data(req_write_data),
        .req_ack(req_ack), .req_read_data(req_read_data), .req_err(req_err),
        .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
        .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
        .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
        .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: phase 0 waiting, 1 on the bus, 2 completion cycle.
    int              m_phase = 0;
    int              m_ptr   = 0;
    int              m_gid   = 0;
    int              m_waits = 0;
    logic            m_is_rd = 1'b0;
    logic [AW-1:0]   m_addr  = '0;
    logic [BW-1:0]   m_be    = '0;
    logic [DW-1:0]   m_wd    = '0;
    logic [DW-1:0]   m_rdata = '0;
    logic [NREQ-1:0] m_ack   = '0;
    logic            m_err   = 1'b0;

    logic [IW-1:0]   exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_phase = 0; m_ptr = 0; m_gid = 0; m_waits = 0;
            m_is_rd = 1'b0; m_rdata = '0; m_ack = '0; m_err = 1'b0;
            return;
        end
        m_ack = '0;
        m_err = 1'b0;
        case (m_phase)
            0: begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (req_read[j] || req_write[j]) begin
                        m_gid   = j;
                        m_is_rd = req_read[j];
                        m_addr  = req_address[j*AW +: AW];
                        m_be    = req_byte_enable[j*BW +: BW];
                        m_wd    = req_write_data[j*DW +: DW];
                        m_waits = 0;
                        m_phase = 1;
                        break;
                    end
                end
            end
            1: begin
                if (bus_acknowledge) begin
                    if (m_is_rd) m_rdata = bus_read_data;
                    m_ack[m_gid] = 1'b1;
                    m_phase = 2;
                end else begin
                    m_waits++;
`ifdef EXT_MASTER_TIMEOUT_EN
                    if (m_waits == TO) begin
                        m_rdata = 32'hDEAD_BEEF;
                        m_err   = 1'b1;
                        m_ack[m_gid] = 1'b1;
                        m_phase = 2;
                    end
`endif
                end
            end
            default: begin
                m_ptr   = (m_gid + 1) % NREQ;
                m_phase = 0;
            end
        endcase
    endtask

    // Compare every cycle against the model.
    task automatic check_all();
        chk("busy", busy, m_phase != 0);
        chk("dbg_state", dbg_state, m_phase);
        chk("req_ack", req_ack, m_ack);
        chk("grant_id", grant_id, m_gid);
        chk("bus_read", bus_read, (m_phase == 1) && m_is_rd);
        chk("bus_write", bus_write, (m_phase == 1) && !m_is_rd);
        if (m_phase == 1) begin
            chk("bus_address", bus_address, m_addr);
            chk("bus_byte_enable", bus_byte_enable, m_be);
            chk("bus_write_data", bus_write_data, m_wd);
        end
        if (m_ack != '0) begin
            chk("req_read_data", req_read_data, m_rdata);
            chk("req_err", req_err, m_err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Driver tasks
    task automatic clear_inputs();
        req_address = '0; req_byte_enable = '0; req_read = '0; req_write = '0;
        req_write_data = '0; bus_acknowledge = 1'b0; bus_read_data = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic start_req(input int i);
        int kind;
        kind = $urandom_range(0, 3);
        req_address[i*AW +: AW]    = AW'($urandom());
        req_byte_enable[i*BW +: BW] = BW'($urandom());
        req_write_data[i*DW +: DW] = $urandom();
        req_read[i]  = (kind == 0) || (kind == 2);
        req_write[i] = (kind != 0);
    endtask

    initial begin
        int n_rd;
        int n_ack;
        int n;
        logic [IW-1:0] g;
        logic [NREQ-1:0] pending;

        clear_inputs();
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_rd", bus_read, 0);
        chk("rst_wr", bus_write, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_addr", bus_address, 0);
        chk("rst_rdata", req_read_data, 0);
        chk("rst_err", req_err, 0);

        // Single read, bridge acks in the third strobe cycle.
        req_read[0] = 1'b1;
        req_address[0 +: AW] = 30'h0000_0400;
        bus_read_data = 32'h1234_5678;
        n_rd = 0; n_ack = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_read) begin
                n_rd++;
                chk("sr_addr", bus_address, 30'h0000_0400);
            end
            if (req_ack != '0) begin
                n_ack++;
                chk("sr_ack", req_ack, 4'b0001);
                chk("sr_rdata", req_read_data, 32'h1234_5678);
                req_read[0] = 1'b0;
                bus_acknowledge = 1'b0;
                break;
            end
            bus_acknowledge = (n_rd == 3);
        end
        chk("sr_rd_cycles", n_rd, 3);
        chk("sr_ack_count", n_ack, 1);
        tick();
        chk("sr_idle_busy", busy, 0);
        chk("sr_ack_gone", req_ack, 0);

        // Round robin with all writes held and a zero-wait bridge.
        clear_inputs();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_write[i] = 1'b1;
            req_write_data[i*DW +: DW] = 32'hA000_0000 + i;
            req_address[i*AW +: AW] = AW'(16 * i);
        end
        bus_acknowledge = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(IW'(k % NREQ));
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (bus_write) chk("rr_wdata", bus_write_data, 32'hA000_0000 + exp_q[0]);
            if (req_ack != '0) begin
                g = exp_q.pop_front();
                chk("rr_grant", grant_id, g);
                chk("rr_ack", req_ack, 4'b0001 << g);
            end
        end
        chk("rr_left", exp_q.size(), 0);

        // Read/write conflict on requester 2.
        clear_inputs();
        do_reset();
        req_read[2] = 1'b1;
        req_write[2] = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (req_ack != '0) begin
                chk("cf_ack", req_ack, 4'b0100);
                break;
            end
            if (busy) begin
                chk("cf_rd", bus_read, 1);
                chk("cf_wr", bus_write, 0);
                n++;
                bus_acknowledge = (n == 2);
            end
        end
        chk("cf_cycles", n, 2);

        // Reset while a read is on the bus.
        clear_inputs();
        do_reset();
        req_read[1] = 1'b1;
        req_address[1*AW +: AW] = 30'h55;
        tick();
        chk("mr_strobe", bus_read, 1);
        reset_n = 1'b0;
        tick();
        chk("mr_busy", busy, 0);
        chk("mr_rd", bus_read, 0);
        chk("mr_ack", req_ack, 0);
        chk("mr_gid", grant_id, 0);
        chk("mr_addr", bus_address, 0);
        reset_n = 1'b1;
        req_read[0] = 1'b1;
        tick();
        chk("mr_next_gid", grant_id, 0);
        chk("mr_next_rd", bus_read, 1);

        // Stray acknowledge in IDLE, then minimum-latency transaction.
        clear_inputs();
        do_reset();
        bus_acknowledge = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("st_busy", busy, 0);
            chk("st_ack", req_ack, 0);
        end
        req_read[3] = 1'b1;
        bus_read_data = 32'h0BAD_F00D;
        tick();
        chk("ml_issue", bus_read, 1);
        tick();
        chk("ml_ack", req_ack, 4'b1000);
        chk("ml_rdata", req_read_data, 32'h0BAD_F00D);
        req_read[3] = 1'b0;
        tick();

`ifdef EXT_MASTER_TIMEOUT_EN
        // Bridge never acknowledges.
        clear_inputs();
        do_reset();
        req_read[1] = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (req_ack != '0) begin
                chk("to_ack", req_ack, 4'b0010);
                chk("to_err", req_err, 1);
                chk("to_rdata", req_read_data, 32'hDEAD_BEEF);
                break;
            end
            if (bus_read) n++;
        end
        chk("to_cycles", n, TO);
        req_read[1] = 1'b0;
        tick();

        // Acknowledge lands in the last allowed cycle.
        clear_inputs();
        do_reset();
        req_read[1] = 1'b1;
        bus_read_data = 32'hCAFE_0001;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (req_ack != '0) begin
                chk("tl_err", req_err, 0);
                chk("tl_rdata", req_read_data, 32'hCAFE_0001);
                break;
            end
            if (bus_read) n++;
            bus_acknowledge = (n == TO);
        end
        chk("tl_cycles", n, TO);
`endif

        // Randomized traffic against the model.
        clear_inputs();
        do_reset();
        pending = '0;
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 499) != 0);
            bus_acknowledge = ($urandom_range(0, 2) == 0);
            bus_read_data = $urandom();
            for (int i = 0; i < NREQ; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(0, 7) != 0) begin
                        req_read[i] = 1'b0;
                        req_write[i] = 1'b0;
                        pending[i] = 1'b0;
                    end
                end else if (!pending[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        start_req(i);
                        pending[i] = 1'b1;
                    end
                end else if (!(m_phase != 0 && m_gid == i) && $urandom_range(0, 7) == 0) begin
                    req_write_data[i*DW +: DW] = $urandom();
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
